// File: rtl/lmc_program_reader_if.sv
// rtl/lmc_program_reader_if.sv - program RAM read port between the reader and the RAM
interface lmc_program_reader_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_rd;
  logic [DATA_WIDTH-1:0] ram_data;

  modport master (output ram_addr, output ram_rd, input ram_data);
  modport slave  (input ram_addr, input ram_rd, output ram_data);
endinterface

// File: rtl/lmc_program_reader.sv
// rtl/lmc_program_reader.sv - fetch/decode/execute engine for the LMC program RAM
module lmc_program_reader #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   timer555,
  input  logic                   reset_count,
  input  logic                   run,
  lmc_program_reader_if.master   ram,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [3:0]             acc_out,
  output logic                   carry,
  output logic [3:0]             out_data,
  output logic                   out_valid,
  output logic                   halted,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [2:0]            ir_op;
  logic [3:0]            ir_imm;
  logic [ADDR_WIDTH-1:0] ir_tgt;
  logic [4:0]            sum;

  always_ff @(posedge timer555) begin
    if (!reset_count) state <= S_IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (run) state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_EXEC;
      S_EXEC: begin
        if (ir_op == OP_HLT) state_next = S_HALT;
        else if (run)        state_next = S_FETCH;
        else                 state_next = S_IDLE;
      end
      S_HALT:  if (!run) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign sum = {1'b0, acc_out} + {1'b0, ir_imm};

  // Architectural state commits at the end of EXEC, so it is visible the following cycle.
  always_ff @(posedge timer555) begin
    if (!reset_count) begin
      pc        <= '0;
      acc_out   <= '0;
      carry     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ir_op     <= '0;
      ir_imm    <= '0;
      ir_tgt    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_WAIT) begin
        ir_op  <= ram.ram_data[7:5];
        ir_imm <= ram.ram_data[3:0];
        ir_tgt <= ram.ram_data[ADDR_WIDTH-1:0];
      end
      if (state == S_HALT && !run) pc <= '0;
      if (state == S_EXEC) begin
        pc <= pc + 1'b1;
        case (ir_op)
          OP_HLT:  pc <= pc;
          OP_LDI: begin
            acc_out <= ir_imm;
            carry   <= 1'b0;
          end
          OP_ADDI: {carry, acc_out} <= sum;
          OP_SUBI: begin
            acc_out <= acc_out - ir_imm;
            carry   <= (acc_out < ir_imm);
          end
          OP_JMP:  pc <= ir_tgt;
          OP_JZ:   if (acc_out == 4'd0) pc <= ir_tgt;
          OP_OUT: begin
            out_data  <= acc_out;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ram.ram_addr = pc;
  assign ram.ram_rd   = (state == S_FETCH);
  assign pc_out       = pc;
  assign halted       = (state == S_HALT);
  assign busy         = (state == S_FETCH) || (state == S_WAIT) || (state == S_EXEC);

endmodule

// File: tb/tb_lmc_program_reader.sv
// tb/tb_lmc_program_reader.sv - directed self-checking bench for lmc_program_reader
module tb_lmc_program_reader;
  logic       timer555 = 1'b0;
  logic       reset_count;
  logic       run;
  logic [1:0] pc_out;
  logic [3:0] acc_out;
  logic       carry;
  logic [3:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       busy;

  logic [7:0] mem [4];
  int         vectors = 0;
  int         errors  = 0;
  int         pulses  = 0;
  bit         fetched2 = 0;
  logic [1:0] fetch_log [$];

  lmc_program_reader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

  lmc_program_reader #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .timer555    (timer555),
    .reset_count (reset_count),
    .run         (run),
    .ram         (bus.master),
    .pc_out      (pc_out),
    .acc_out     (acc_out),
    .carry       (carry),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .halted      (halted),
    .busy        (busy)
  );

  always #5 timer555 = ~timer555;

  // Synchronous RAM: data valid one cycle after the read strobe.
  initial bus.ram_data = 8'h00;
  always @(posedge timer555) if (bus.ram_rd) bus.ram_data <= mem[bus.ram_addr];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge timer555);
      #1;
      if (out_valid) pulses++;
      if (bus.ram_rd) begin
        fetch_log.push_back(bus.ram_addr);
        if (bus.ram_addr == 2'd2) fetched2 = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] w0, input logic [7:0] w1,
                      input logic [7:0] w2, input logic [7:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  // Reset for two cycles, then release with run high; block sits in IDLE.
  task automatic restart();
    reset_count = 1'b0;
    run = 1'b0;
    tick(2);
    reset_count = 1'b1;
    run = 1'b1;
    pulses = 0;
    fetched2 = 0;
    fetch_log.delete();
  endtask

  initial begin
    reset_count = 1'b0;
    run = 1'b1;
    load(8'h21, 8'h45, 8'hC0, 8'h00);
    tick(2);
    check("rst_pc", pc_out, 0);
    check("rst_acc", acc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_rd", bus.ram_rd, 0);
    check("rst_out_valid", out_valid, 0);

    // Basic program: LDI 1, ADDI 5, OUT, HLT
    restart();
    tick(1);
    check("basic_fetch0_rd", bus.ram_rd, 1);
    check("basic_fetch0_addr", bus.ram_addr, 0);
    tick(8);
    check("basic_out_valid_pre", out_valid, 0);
    tick(1);
    check("basic_out_valid", out_valid, 1);
    check("basic_out_data", out_data, 6);
    tick(1);
    check("basic_out_valid_drop", out_valid, 0);
    tick(1);
    check("basic_not_halted_yet", halted, 0);
    tick(1);
    check("basic_halted", halted, 1);
    check("basic_pc", pc_out, 3);
    check("basic_acc", acc_out, 6);
    check("basic_busy_in_halt", busy, 0);
    check("basic_pulses", pulses, 1);

    // Add with carry: LDI 15, ADDI 2 -> 17
    restart();
    load(8'h2F, 8'h42, 8'hC0, 8'h00);
    tick(13);
    check("addc_halted", halted, 1);
    check("addc_acc", acc_out, 1);
    check("addc_carry", carry, 1);
    check("addc_out", out_data, 1);

    // Subtract with borrow: LDI 2, SUBI 5 -> 13
    restart();
    load(8'h22, 8'h65, 8'hC0, 8'h00);
    tick(13);
    check("subb_acc", acc_out, 13);
    check("subb_carry", carry, 1);
    check("subb_out", out_data, 13);

    // Jump and wrap: LDI 0, JZ 3, LDI 15 (skipped), NOP
    restart();
    load(8'h20, 8'hA3, 8'h2F, 8'hE0);
    tick(30);
    check("jmp_never_fetch2", fetched2, 0);
    check("jmp_log_len_ok", fetch_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_pc;
      exp_pc = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd1 : 2'd3;
      check($sformatf("jmp_seq%0d", i), fetch_log[i], exp_pc);
    end
    check("jmp_halted", halted, 0);

    // Pause during WAIT of pc=1, then resume
    restart();
    load(8'h21, 8'h45, 8'hC0, 8'h00);
    tick(5);
    run = 1'b0;
    tick(2);
    check("pause_busy", busy, 0);
    check("pause_pc", pc_out, 2);
    check("pause_acc", acc_out, 6);
    tick(3);
    check("pause_still_idle", busy, 0);
    run = 1'b1;
    tick(1);
    check("resume_rd", bus.ram_rd, 1);
    check("resume_addr", bus.ram_addr, 2);

    // Continue to HALT, then release it
    tick(6);
    check("halt_reached", halted, 1);
    check("halt_pc", pc_out, 3);
    tick(3);
    check("halt_stays_run1", halted, 1);
    run = 1'b0;
    tick(1);
    check("halt_release", halted, 0);
    check("halt_release_pc", pc_out, 0);
    check("halt_release_busy", busy, 0);

    // Reset during EXEC of OUT suppresses the pulse
    pulses = 0;
    run = 1'b1;
    tick(9);
    check("midrst_in_exec", busy, 1);
    reset_count = 1'b0;
    tick(1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_acc", acc_out, 0);
    check("midrst_pc", pc_out, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_carry", carry, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd", bus.ram_rd, 0);
    tick(2);
    check("midrst_no_pulse", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/lmc_program_reader.md
Name: lmc_program_reader

Overview:
- Reader end of the program RAM that the button-driven loader fills. Once `run` is asserted, it walks the RAM from address 0 and fetches each 8-bit word.
- It decodes each word and executes it on a 4-bit accumulator, then presents results on an output port.
- It sits between the program RAM read port and the display/accumulator path of the LMC board.

Parameters:
- ADDR_WIDTH, 2, width of the program counter and RAM address.
- DATA_WIDTH, 8, RAM word width. The decode below requires DATA_WIDTH = 8.

Ports:
- timer555  input  1  system clock, rising edge.
- reset_count  input  1  synchronous, active-low reset.
- run  input  1  level: 1 = execute, 0 = pause/stop.
- ram_addr  output  ADDR_WIDTH  RAM read address (equals pc).
- ram_rd  output  1  read strobe, 1 cycle in FETCH.
- ram_data  input  DATA_WIDTH  RAM read data, valid one cycle after ram_rd.
- pc_out  output  ADDR_WIDTH  current program counter.
- acc_out  output  4  accumulator.
- carry  output  1  carry/borrow from the last ADDI/SUBI.
- out_data  output  4  value latched by OUT.
- out_valid  output  1  1-cycle pulse when out_data updates.
- halted  output  1  high while in HALT.
- busy  output  1  high in FETCH/WAIT/EXEC.

Behaviour:
- Reset (reset_count == 0 at a clock edge) forces:
  - state = IDLE;
  - pc, acc_out, carry, out_data = 0;
  - out_valid, ram_rd, halted, busy = 0.
  - Reset wins over all other inputs, including mid-instruction.
- Instruction word format:
  - op = ram_data[7:5];
  - imm = ram_data[3:0];
  - tgt = ram_data[ADDR_WIDTH-1:0];
  - bit 4 is ignored.
- Opcodes:
  - 000 HLT: go to HALT; pc unchanged.
  - 001 LDI: acc = imm; carry = 0.
  - 010 ADDI: {carry, acc} = acc + imm (5-bit sum; acc keeps the low 4 bits).
  - 011 SUBI: acc = (acc - imm) mod 16; carry = 1 if acc < imm (borrow), else 0.
  - 100 JMP: pc = tgt.
  - 101 JZ: pc = tgt if acc == 0, else pc + 1.
  - 110 OUT: out_data = acc; out_valid = 1 for exactly one cycle.
  - 111 NOP.
  - Every non-jump, non-HLT opcode sets pc = pc + 1.
- PC arithmetic: pc + 1 wraps from 2^ADDR_WIDTH - 1 to 0. There is no fault on wrap.
- FSM states: IDLE, FETCH, WAIT, EXEC, HALT.
  - IDLE: busy = 0. If run == 1, go to FETCH; pc is retained, not cleared.
  - FETCH: ram_addr = pc, ram_rd = 1; go to WAIT.
  - WAIT: register ram_data into the instruction register at the end of this cycle; go to EXEC.
  - EXEC: apply the opcode.
    - HLT goes to HALT.
    - Otherwise, go to FETCH if run == 1, else to IDLE.
  - HALT: halted = 1; hold pc/acc.
    - Leave to IDLE only when run == 0, so a fresh run edge is needed.
    - pc is cleared to 0 on the HALT -> IDLE transition.
- Timing:
  - Each instruction takes 3 cycles: FETCH, WAIT, EXEC.
  - Architectural updates (acc, carry, pc, out_data) are visible the cycle after EXEC.
  - out_valid is asserted in that same following cycle.
- Pause: run dropping during FETCH/WAIT does not abort. The current instruction completes in EXEC, then the block goes to IDLE. Re-asserting run resumes at the saved pc.
- ram_addr is driven from pc at all times; only ram_rd qualifies the read.
- No combinational path from ram_data to any output.

Test Plan:
- Reset: hold reset_count = 0 for 2 cycles with run = 1 -> pc = 0, acc = 0, halted = 0, busy = 0, ram_rd = 0.
- Basic program:
  - RAM = {0x21 LDI 1, 0x45 ADDI 5, 0xC0 OUT, 0x00 HLT}; run = 1.
  - Required: out_valid pulses once with out_data = 6, the cycle after the 3rd EXEC; halted = 1 after 12 cycles; pc = 3.
- Carry/borrow:
  - RAM = {0x2F, 0x42, 0xC0, 0x00} -> acc = 1, carry = 1, out_data = 1.
  - RAM = {0x22, 0x65, 0xC0, 0x00} -> acc = 13, carry = 1.
- Jump and wrap:
  - RAM = {0x20 LDI 0, 0xA3 JZ 3, 0x2F, 0xE0 NOP}, run held high.
  - Required: pc sequence 0, 1, 3, 0, 1, 3, ... (wrap after addr 3); address 2 is never fetched (ram_rd is never issued with ram_addr = 2).
- Pause/resume:
  - Drop run during WAIT of the instruction at pc = 1 -> that instruction completes, then IDLE with pc = 2, busy = 0.
  - Re-raise run -> next ram_rd has ram_addr = 2.
- Halt release and mid-op reset:
  - In HALT with run = 1 -> stays halted.
  - run = 0 -> IDLE, pc = 0.
  - Assert reset_count = 0 during EXEC of OUT -> no out_valid pulse; all outputs 0 on the next cycle.
